// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine for the EXE stage.
// Multiply takes one cycle; divide uses radix-2 restoring steps with a final sign fixup.
module mul_div_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  EXE_MultDivOp,
  input  logic [31:0] EXE_rs_data,
  input  logic [31:0] EXE_rt_data,
  input  logic        EXE_Wr,
  input  logic        HiLo_Not_Flush,
  output logic        DIVMULTBusy,
  output logic        EXE_MultDivDone,
  output logic [31:0] EXE_Hi,
  output logic [31:0] EXE_Lo
);

  localparam int CW = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state_reg, state_next;
  logic            op_valid, op_is_div, op_signed, start, last_step;
  logic            sgn_reg, neg_q_reg, neg_r_reg;
  logic [31:0]     a_reg, b_reg, rem_reg, quo_reg, hi_reg, lo_reg;
  logic [CW-1:0]   cnt_reg;
  logic [31:0]     rs_mag, rt_mag;
  logic signed [32:0] a_ext, b_ext;
  logic signed [65:0] product;
  logic [32:0]     trial, diff;
  logic            quo_bit;
  logic [31:0]     rem_step, quo_step;

  assign op_valid  = (EXE_MultDivOp >= 3'd1) && (EXE_MultDivOp <= 3'd4);
  assign op_is_div = (EXE_MultDivOp == 3'd3) || (EXE_MultDivOp == 3'd4);
  assign op_signed = (EXE_MultDivOp == 3'd1) || (EXE_MultDivOp == 3'd3);
  assign start     = (state_reg == IDLE) && op_valid && HiLo_Not_Flush;
  assign last_step = (cnt_reg == CW'(DIV_CYCLES - 1));

  assign rs_mag = (op_signed && EXE_rs_data[31]) ? -EXE_rs_data : EXE_rs_data;
  assign rt_mag = (op_signed && EXE_rt_data[31]) ? -EXE_rt_data : EXE_rt_data;

  // MULTU zero-extends to 33 bits, MULT sign-extends; the low 64 bits are the result.
  assign a_ext   = {sgn_reg & a_reg[31], a_reg};
  assign b_ext   = {sgn_reg & b_reg[31], b_reg};
  assign product = a_ext * b_ext;

  // One restoring step: a zero divisor always subtracts, giving all-ones and rem=|rs|.
  assign trial    = {rem_reg, quo_reg[31]};
  assign diff     = trial - {1'b0, b_reg};
  assign quo_bit  = (trial >= {1'b0, b_reg});
  assign rem_step = quo_bit ? diff[31:0] : trial[31:0];
  assign quo_step = {quo_reg[30:0], quo_bit};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!HiLo_Not_Flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (op_valid) state_next = op_is_div ? DIV : MUL;
        MUL:  state_next = DONE;
        DIV:  if (last_step) state_next = DONE;
        DONE: if (EXE_Wr) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    DIVMULTBusy     = 1'b0;
    EXE_MultDivDone = 1'b0;
    if (HiLo_Not_Flush) begin
      DIVMULTBusy     = (state_reg == MUL) || (state_reg == DIV) ||
                        ((state_reg == IDLE) && op_valid);
      EXE_MultDivDone = (state_reg == DONE);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sgn_reg   <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else if (start) begin
      sgn_reg   <= op_signed;
      neg_q_reg <= op_signed && (EXE_rs_data[31] ^ EXE_rt_data[31]);
      neg_r_reg <= op_signed && EXE_rs_data[31];
      a_reg     <= op_is_div ? rs_mag : EXE_rs_data;
      b_reg     <= op_is_div ? rt_mag : EXE_rt_data;
      quo_reg   <= rs_mag;
      rem_reg   <= '0;
      cnt_reg   <= '0;
    end else if (HiLo_Not_Flush) begin
      if (state_reg == MUL) begin
        hi_reg <= product[63:32];
        lo_reg <= product[31:0];
      end else if (state_reg == DIV) begin
        rem_reg <= rem_step;
        quo_reg <= quo_step;
        cnt_reg <= cnt_reg + 1'b1;
        if (last_step) begin
          hi_reg <= neg_r_reg ? -rem_step : rem_step;
          lo_reg <= neg_q_reg ? -quo_step : quo_step;
        end
      end
    end
  end

  assign EXE_Hi = hi_reg;
  assign EXE_Lo = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: multiply, divide, stall, abort and reset cases.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  EXE_MultDivOp;
  logic [31:0] EXE_rs_data, EXE_rt_data;
  logic        EXE_Wr, HiLo_Not_Flush;
  logic        DIVMULTBusy, EXE_MultDivDone;
  logic [31:0] EXE_Hi, EXE_Lo;

  int n_assert = 0;
  int n_fail   = 0;

  mul_div_unit #(.DIV_CYCLES(32)) dut (
    .clk(clk), .resetn(resetn), .EXE_MultDivOp(EXE_MultDivOp),
    .EXE_rs_data(EXE_rs_data), .EXE_rt_data(EXE_rt_data), .EXE_Wr(EXE_Wr),
    .HiLo_Not_Flush(HiLo_Not_Flush), .DIVMULTBusy(DIVMULTBusy),
    .EXE_MultDivDone(EXE_MultDivDone), .EXE_Hi(EXE_Hi), .EXE_Lo(EXE_Lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, count busy cycles, check result; hold DONE for `hold` cycles with EXE_Wr=0.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy, input logic [31:0] eh,
                        input logic [31:0] el, input int hold);
    int busy_cnt;
    @(negedge clk);
    EXE_MultDivOp = op; EXE_rs_data = a; EXE_rt_data = b;
    EXE_Wr = (hold == 0);
    #1;
    busy_cnt = 0;
    for (int i = 0; i < 100 && DIVMULTBusy; i++) begin
      busy_cnt++;
      @(negedge clk);
      EXE_MultDivOp = 3'd0; EXE_rs_data = $urandom; EXE_rt_data = $urandom;
      #1;
    end
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, " done"}, {31'd0, EXE_MultDivDone}, 32'd1);
    check({tag, " hi"}, EXE_Hi, eh);
    check({tag, " lo"}, EXE_Lo, el);
    $display("op %0d rs=%h rt=%h busy=%0d hi=%h lo=%h", op, a, b, busy_cnt, EXE_Hi, EXE_Lo);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      check({tag, " hold done"}, {31'd0, EXE_MultDivDone}, 32'd1);
      check({tag, " hold busy"}, {31'd0, DIVMULTBusy}, 32'd0);
      check({tag, " hold lo"}, EXE_Lo, el);
    end
    EXE_Wr = 1'b1;
    @(negedge clk); #1;
    check({tag, " idle done"}, {31'd0, EXE_MultDivDone}, 32'd0);
    check({tag, " idle busy"}, {31'd0, DIVMULTBusy}, 32'd0);
  endtask

  initial begin
    resetn = 1'b0; EXE_MultDivOp = 3'd0; EXE_rs_data = '0; EXE_rt_data = '0;
    EXE_Wr = 1'b1; HiLo_Not_Flush = 1'b1;
    #1;
    check("reset busy", {31'd0, DIVMULTBusy}, 32'd0);
    check("reset done", {31'd0, EXE_MultDivDone}, 32'd0);
    check("reset hi", EXE_Hi, 32'd0);
    check("reset lo", EXE_Lo, 32'd0);
    @(negedge clk); resetn = 1'b1;

    run_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 2, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
    run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 2, 32'h00000002, 32'hFFFFFFFA, 0);
    run_op("mult_min", 3'd1, 32'h80000000, 32'h80000000, 2, 32'h40000000, 32'h0, 0);
    run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("div_negdiv", 3'd3, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD, 0);
    run_op("div_zero", 3'd3, 32'hFFFFFFFB, 32'd0, 33, 32'hFFFFFFFB, 32'd1, 0);
    run_op("divu_stall", 3'd4, 32'd100, 32'd7, 33, 32'd2, 32'd14, 3);

    // Start blocked by a flush in the IDLE cycle
    @(negedge clk);
    EXE_MultDivOp = 3'd1; EXE_rs_data = 32'd9; EXE_rt_data = 32'd9; HiLo_Not_Flush = 1'b0;
    #1;
    check("flush_idle busy", {31'd0, DIVMULTBusy}, 32'd0);
    @(negedge clk); EXE_MultDivOp = 3'd0; HiLo_Not_Flush = 1'b1; #1;
    check("flush_idle done", {31'd0, EXE_MultDivDone}, 32'd0);
    check("flush_idle lo", EXE_Lo, 32'd14);

    // Abort at the tenth divide step
    @(negedge clk); EXE_MultDivOp = 3'd3; EXE_rs_data = 32'd50; EXE_rt_data = 32'd6;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); EXE_MultDivOp = 3'd0;
    end
    @(negedge clk); HiLo_Not_Flush = 1'b0; #1;
    check("abort busy", {31'd0, DIVMULTBusy}, 32'd0);
    check("abort done", {31'd0, EXE_MultDivDone}, 32'd0);
    @(negedge clk); HiLo_Not_Flush = 1'b1; #1;
    check("abort idle busy", {31'd0, DIVMULTBusy}, 32'd0);
    check("abort hi kept", EXE_Hi, 32'd2);
    check("abort lo kept", EXE_Lo, 32'd14);
    run_op("after_abort", 3'd1, 32'd7, 32'hFFFFFFFD, 2, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);

    // Asynchronous reset in the middle of a divide
    @(negedge clk); EXE_MultDivOp = 3'd4; EXE_rs_data = 32'd1000; EXE_rt_data = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); EXE_MultDivOp = 3'd0;
    end
    #2 resetn = 1'b0; #1;
    check("midreset busy", {31'd0, DIVMULTBusy}, 32'd0);
    check("midreset done", {31'd0, EXE_MultDivDone}, 32'd0);
    check("midreset hi", EXE_Hi, 32'd0);
    check("midreset lo", EXE_Lo, 32'd0);
    @(negedge clk); resetn = 1'b1;

    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000, 0);
    run_op("divu_zero", 3'd4, 32'd5, 32'd0, 33, 32'd5, 32'hFFFFFFFF, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
